// File: rtl/branch_resolve_unit.sv
// Fetch-side branch resolution: drives the fetch PC stream, queues {pc, pred} pairs
// in flight, checks them against execute, redirects on mispredict and trains the predictor.
module branch_resolve_unit #(
    parameter int PC_W     = 5,
    parameter int DEPTH    = 4,
    parameter int INC      = 4,
    parameter int RESET_PC = 0,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   fetch_pc,
    output logic              fetch_valid,
    input  logic [PC_W-1:0]   pred_next_pc,
    input  logic              exe_valid,
    input  logic [PC_W-1:0]   exe_actual_pc,
    output logic              upd_valid,
    output logic [PC_W-1:0]   upd_pc,
    output logic [PC_W-1:0]   upd_target,
    output logic              upd_taken,
    output logic              redirect,
    output logic [CNT_W-1:0]  correct_cnt,
    output logic [CNT_W-1:0]  mispredict_cnt,
    output logic              full,
    output logic              empty,
    output logic              protocol_err
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W + 1)'(DEPTH);

    logic [PC_W-1:0]  mem_pc_q   [DEPTH];
    logic [PC_W-1:0]  mem_pred_q [DEPTH];

    logic [PC_W-1:0]  fetch_pc_q, fetch_pc_d;
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [CNT_W-1:0] correct_cnt_q, correct_cnt_d, mispredict_cnt_q, mispredict_cnt_d;
    logic             protocol_err_q, protocol_err_d;
    logic             upd_valid_q, upd_valid_d, upd_taken_q, upd_taken_d;
    logic [PC_W-1:0]  upd_pc_q, upd_pc_d, upd_target_q, upd_target_d;
    logic             redirect_q, redirect_d;

    logic             push, pop, mispred;
    logic [PC_W-1:0]  head_pc, head_pred;

    assign full        = (count_q == FULL_CNT);
    assign empty       = (count_q == '0);
    assign fetch_valid = !full;
    assign head_pc     = mem_pc_q[head_q];
    assign head_pred   = mem_pred_q[head_q];

    // A mispredict kills the same-cycle push: that fetch was down the wrong path.
    assign pop     = exe_valid && !empty;
    assign mispred = pop && (head_pred != exe_actual_pc);
    assign push    = fetch_valid && !mispred;

    always_comb begin
        fetch_pc_d       = fetch_pc_q;
        head_d           = head_q;
        tail_d           = tail_q;
        count_d          = count_q + {{PTR_W{1'b0}}, push} - {{PTR_W{1'b0}}, pop};
        correct_cnt_d    = correct_cnt_q;
        mispredict_cnt_d = mispredict_cnt_q;
        protocol_err_d   = protocol_err_q || (exe_valid && empty);
        upd_valid_d      = pop;
        upd_pc_d         = upd_pc_q;
        upd_target_d     = upd_target_q;
        upd_taken_d      = upd_taken_q;
        redirect_d       = mispred;

        if (push) begin
            tail_d     = tail_q + PTR_W'(1);
            fetch_pc_d = pred_next_pc;
        end
        if (pop) begin
            head_d       = head_q + PTR_W'(1);
            upd_pc_d     = head_pc;
            upd_target_d = exe_actual_pc;
            upd_taken_d  = (exe_actual_pc != PC_W'(head_pc + PC_W'(INC)));
        end
        if (mispred) begin
            count_d    = '0;
            head_d     = tail_q;
            fetch_pc_d = exe_actual_pc;
            if (mispredict_cnt_q != {CNT_W{1'b1}})
                mispredict_cnt_d = mispredict_cnt_q + CNT_W'(1);
        end else if (pop) begin
            if (correct_cnt_q != {CNT_W{1'b1}})
                correct_cnt_d = correct_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc_q       <= PC_W'(RESET_PC);
            head_q           <= '0;
            tail_q           <= '0;
            count_q          <= '0;
            correct_cnt_q    <= '0;
            mispredict_cnt_q <= '0;
            protocol_err_q   <= 1'b0;
            upd_valid_q      <= 1'b0;
            upd_pc_q         <= '0;
            upd_target_q     <= '0;
            upd_taken_q      <= 1'b0;
            redirect_q       <= 1'b0;
        end else begin
            fetch_pc_q       <= fetch_pc_d;
            head_q           <= head_d;
            tail_q           <= tail_d;
            count_q          <= count_d;
            correct_cnt_q    <= correct_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
            protocol_err_q   <= protocol_err_d;
            upd_valid_q      <= upd_valid_d;
            upd_pc_q         <= upd_pc_d;
            upd_target_q     <= upd_target_d;
            upd_taken_q      <= upd_taken_d;
            redirect_q       <= redirect_d;
        end
    end

    // Queue storage needs no reset: occupancy is tracked by count/pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_pc_q[tail_q]   <= fetch_pc_q;
            mem_pred_q[tail_q] <= pred_next_pc;
        end
    end

    assign fetch_pc       = fetch_pc_q;
    assign correct_cnt    = correct_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
    assign protocol_err   = protocol_err_q;
    assign upd_valid      = upd_valid_q;
    assign upd_pc         = upd_pc_q;
    assign upd_target     = upd_target_q;
    assign upd_taken      = upd_taken_q;
    assign redirect       = redirect_q;
endmodule
